// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// and feeds {pc, instr, valid} to IF/ID with stall, skid buffer and redirect support.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] target_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] skid_instr_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic        valid_reg;
  logic [31:0] cnt_reg;
  logic [31:0] redirect_tgt;
  logic        unused_bits;

  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
  assign unused_bits  = ^redirect_pc_i[1:0];

  assign imem_req_o  = (state_reg == S_WAIT) || (state_reg == S_DROP);
  assign imem_addr_o = addr_reg;
  assign pc_o        = pc_reg;
  assign instr_o     = instr_reg;
  assign valid_o     = valid_reg;
  assign fetch_cnt_o = cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= S_IDLE;
      addr_reg       <= RESET_PC;
      target_reg     <= 32'h0;
      skid_pc_reg    <= 32'h0;
      skid_instr_reg <= 32'h0;
      pc_reg         <= 32'h0;
      instr_reg      <= NOP_INSTR;
      valid_reg      <= 1'b0;
      cnt_reg        <= 32'h0;
    end else if (redirect_i) begin
      // Flush beats stall: IF/ID must not see a wrong-path instruction.
      if (state_reg != S_IDLE) begin
        valid_reg <= 1'b0;
        instr_reg <= NOP_INSTR;
      end
      if (imem_req_o && !imem_ack_i) begin
        // The in-flight request cannot be cancelled; remember where to go after it lands.
        target_reg <= redirect_tgt;
        state_reg  <= S_DROP;
      end else begin
        addr_reg  <= redirect_tgt;
        state_reg <= S_WAIT;
      end
    end else begin
      case (state_reg)
        S_IDLE: state_reg <= S_WAIT;
        S_WAIT: begin
          if (imem_ack_i) begin
            addr_reg <= addr_reg + 32'd4;
            if (!stall_i) begin
              pc_reg    <= addr_reg;
              instr_reg <= imem_rdata_i;
              valid_reg <= 1'b1;
              cnt_reg   <= cnt_reg + 32'd1;
            end else begin
              skid_pc_reg    <= addr_reg;
              skid_instr_reg <= imem_rdata_i;
              state_reg      <= S_HOLD;
            end
          end else if (!stall_i) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            pc_reg    <= skid_pc_reg;
            instr_reg <= skid_instr_reg;
            valid_reg <= 1'b1;
            cnt_reg   <= cnt_reg + 32'd1;
            state_reg <= S_WAIT;
          end
        end
        S_DROP: begin
          if (imem_ack_i) begin
            addr_reg  <= target_reg;
            state_reg <= S_WAIT;
          end
          if (!stall_i) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: variable-latency memory, random stalls,
// redirects and resets, checked against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, ack;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req, valid;
  logic [31:0] imem_addr, pc, instr, fetch_cnt;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata),
    .pc_o         (pc),
    .instr_o      (instr),
    .valid_o      (valid),
    .fetch_cnt_o  (fetch_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: program-order fetch address, captured-but-undelivered
  // instructions, and whether the in-flight request belongs to a flushed path.
  ent_t        m_q[$];
  logic        m_idle, m_stale, m_valid;
  logic [31:0] m_fetch_pc, m_pc, m_instr, m_cnt;

  int          mem_cnt, mem_lat, lat_lo, lat_hi;
  logic        prev_hold;
  logic [31:0] prev_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc,
                            input logic st, input logic ak);
    logic req_m;
    ent_t e;
    req_m = !m_idle && (m_q.size() == 0);
    if (r) begin
      m_q.delete();
      m_idle = 1'b1; m_stale = 1'b0; m_fetch_pc = RESET_PC;
      m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      if (!m_idle) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      m_stale    = req_m && !ak;
      m_fetch_pc = {rpc[31:2], 2'b00};
      m_q.delete();
      m_idle = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      if (req_m && ak) begin
        if (m_stale) m_stale = 1'b0;
        else begin
          e.pc = m_fetch_pc;
          e.instr = mem_word(m_fetch_pc);
          m_q.push_back(e);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
      if (!st) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_pc = e.pc; m_instr = e.instr; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
          $display("deliver pc=%h instr=%h cnt=%0d", m_pc, m_instr, m_cnt);
        end else begin
          m_valid = 1'b0;
          m_instr = NOP;
        end
      end
    end
  endtask

  task automatic set_latency(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi; mem_lat = lo; mem_cnt = 0;
  endtask

  task automatic run_cycle(input int p_stall, input int p_redir, input int p_rst, input int p_spur);
    @(negedge clk);
    check("valid", valid, m_valid);
    check("pc", pc, m_pc);
    check("instr", instr, m_instr);
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("req", imem_req, !m_idle && (m_q.size() == 0));
    if (prev_hold) check("addr_stable", imem_addr, prev_addr);
    if (imem_req && !m_stale) check("fetch_addr", imem_addr, m_fetch_pc);

    rst      = ($urandom % 100) < p_rst;
    redirect = ($urandom % 100) < p_redir;
    stall    = ($urandom % 100) < p_stall;
    case ($urandom % 4)
      0: redirect_pc = 32'h0000_0102;
      1: redirect_pc = 32'hFFFF_FFFC;
      2: redirect_pc = 32'hFFFF_FFF5;
      default: redirect_pc = $urandom;
    endcase

    if (imem_req) begin
      if (mem_cnt >= mem_lat) begin
        ack = 1'b1;
        mem_cnt = 0;
        mem_lat = $urandom_range(lat_hi, lat_lo);
      end else begin
        ack = 1'b0;
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
      ack = ($urandom % 100) < p_spur;
    end
    rdata = mem_word(imem_addr);

    prev_hold = imem_req && !ack && !rst;
    prev_addr = imem_addr;
    model_step(rst, redirect, redirect_pc, stall, ack);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack = 1'b0; rdata = 32'h0; prev_hold = 1'b0; prev_addr = 32'h0;
    set_latency(0, 0);
    model_step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);

    // Zero-wait memory streaming
    for (int i = 0; i < 20; i++) run_cycle(0, 0, 0, 0);
    // Fixed 3-cycle latency
    set_latency(2, 2);
    for (int i = 0; i < 30; i++) run_cycle(0, 0, 0, 0);
    // Mixed latency with stalls
    set_latency(0, 3);
    for (int i = 0; i < 150; i++) run_cycle(35, 0, 0, 10);
    // Everything at once, including resets mid-request
    for (int i = 0; i < 300; i++) run_cycle(30, 8, 2, 10);
    // Zero-wait with frequent redirects (address wrap exercised)
    set_latency(0, 0);
    for (int i = 0; i < 150; i++) run_cycle(20, 12, 0, 0);
    // Short latency with frequent resets
    set_latency(1, 2);
    for (int i = 0; i < 100; i++) run_cycle(20, 5, 15, 5);
    set_latency(0, 1);
    for (int i = 0; i < 20; i++) run_cycle(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues word fetches to a variable-latency instruction memory over a req/ack handshake. It delivers {pc_o, instr_o, valid_o} to IF/ID, honours the hazard stall, and handles branch/jump redirects, including redirects that arrive while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven on instr_o when valid_o=0 (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
stall_i  in  1  hazard unit: IF/ID must not change; hold pc_o/instr_o/valid_o
redirect_i  in  1  one-cycle pulse: branch taken / jump; flush and refetch
redirect_pc_i  in  32  redirect target; bits [1:0] ignored, forced to 00
imem_req_o  out  1  fetch request, held until ack
imem_addr_o  out  32  fetch address, stable while imem_req_o=1
imem_ack_i  in  1  one-cycle pulse; imem_rdata_i valid; only meaningful while imem_req_o=1
imem_rdata_i  in  32  fetched instruction
pc_o  out  32  PC of instr_o, to IF/ID
instr_o  out  32  instruction, to IF/ID
valid_o  out  1  instr_o is real (0 = bubble)
fetch_cnt_o  out  32  instructions delivered since reset, wraps

Behaviour:
- All state is registered. Outputs change only on a rising edge.
- Reset (rst_i=1 at an edge) overrides everything, including mid-request:
  - state=IDLE, imem_addr_o=RESET_PC, imem_req_o=0.
  - pc_o=0, instr_o=NOP_INSTR, valid_o=0, fetch_cnt_o=0.
  - Skid buffer and pending target are cleared.
  - An ack arriving in the reset cycle is ignored.
- imem_req_o=1 exactly when state is WAIT or DROP. Address increment is +4, modulo 2^32 (32'hFFFF_FFFC -> 0).
- States:
  - IDLE: next edge -> WAIT.
  - WAIT: request outstanding.
  - HOLD: instruction captured in the skid buffer while stalled; no request.
  - DROP: outstanding request must be discarded.
- "Deliver X" means: pc_o<=X.pc, instr_o<=X.instr, valid_o<=1, fetch_cnt_o+=1.
- "Bubble" means: valid_o<=0, instr_o<=NOP_INSTR; pc_o is held.
- Priority at an edge: reset > redirect > ack/stall handling.
- Redirect, any state except IDLE:
  - valid_o<=0 and instr_o<=NOP_INSTR, even if stall_i=1 (flush beats stall).
  - Skid buffer is discarded.
  - WAIT/DROP without ack: target<={redirect_pc_i[31:2],2'b00}, go to DROP. imem_addr_o is held.
  - WAIT/DROP with ack in the same cycle: data discarded, imem_addr_o<=target, go to WAIT.
  - HOLD: imem_addr_o<=target, go to WAIT.
  - IDLE: imem_addr_o<=target, go to WAIT.
- WAIT, ack, no redirect:
  - stall_i=0: deliver {imem_addr_o, imem_rdata_i}, imem_addr_o+=4, stay in WAIT. A zero-wait memory therefore sustains 1 instruction/cycle.
  - stall_i=1: skid<={imem_addr_o, imem_rdata_i}, imem_addr_o+=4, go to HOLD. Outputs are held.
- WAIT, no ack, no redirect: stall_i=0 gives a bubble; stall_i=1 holds outputs.
- HOLD, no redirect: stall_i=0 delivers skid and goes to WAIT; stall_i=1 stays in HOLD.
- DROP, no redirect: on ack, data discarded, imem_addr_o<=target, go to WAIT. Without ack, stay in DROP. In both cases, stall_i=0 gives a bubble and stall_i=1 holds outputs.
- Invariant: at most one outstanding request and at most one skid entry. Instructions are never lost or duplicated without a redirect.

Test Plan:
1. Reset then zero-wait memory (ack whenever req, rdata=addr^32'hA5A5_0000): after IDLE, pc_o steps 0,4,8,12 on consecutive edges with valid_o=1 and matching instr_o; fetch_cnt_o=4.
2. 3-cycle-latency memory: imem_addr_o is stable for 3 cycles per fetch; valid_o pattern is 0,0,1 repeating; pc_o is 0,4,8 on each valid cycle.
3. stall_i=1 for 4 cycles spanning an ack at addr 8: outputs hold pc 4 throughout, req drops (HOLD); on release pc_o=8 next edge, then 12; no gaps or duplicates.
4. Redirect to 32'h0000_0102 while WAIT at addr 0x10, ack 2 cycles later: addr-0x10 data never appears; valid_o=0 until the first instruction with pc_o=32'h100 arrives.
5. Redirect with simultaneous ack and stall_i=1: valid_o=0 next edge, next imem_addr_o is the target; then redirect to 32'hFFFF_FFFC with zero-wait memory: pc_o sequence FFFF_FFFC, 0000_0000.
6. rst_i asserted mid-WAIT with ack in the same cycle: the ack is ignored, all outputs return to reset values, and fetch restarts at RESET_PC two edges later.
